// File: rtl/hazard_scoreboard.sv
// Issue controller for the ID stage: per-register writeback countdowns,
// RAW hazard stall, memory freeze and branch flush sequencing.
module hazard_scoreboard #(
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int WB_LAT = 3,
  parameter int PCW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_check_rs,
  input  logic            id_check_rt,
  input  logic            id_writes,
  input  logic            mem_busy,
  input  logic            ex_flush,
  output logic            stall,
  output logic            issue,
  output logic [NREG-1:0] pending,
  output logic [1:0]      state,
  output logic [PCW-1:0]  stall_cycles
);

  localparam int CW = $clog2(WB_LAT + 1);

  typedef enum logic [1:0] {
    RUN = 2'b00,
    HAZ = 2'b01,
    FRZ = 2'b10
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt [NREG];
  logic          rs_busy;
  logic          rt_busy;
  logic          haz;

  // rt is only meaningful for two-source instructions
  assign rs_busy = id_check_rs & (cnt[id_rs] != '0);
  assign rt_busy = id_check_rs & id_check_rt & (cnt[id_rt] != '0);
  assign haz     = id_valid & (rs_busy | rt_busy);

  always_comb begin
    stall = 1'b0;
    issue = 1'b0;
    if (mem_busy) begin
      stall = 1'b0;
      issue = 1'b0;
    end else if (ex_flush) begin
      stall = 1'b0;
      issue = 1'b0;
    end else begin
      stall = haz;
      issue = id_valid & ~haz;
    end
  end

  // a fresh issue to rd overrides that register's decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (!mem_busy) begin
      for (int r = 0; r < NREG; r++) begin
        if (issue && id_writes && (id_rd == AW'(r)))
          cnt[r] <= CW'(WB_LAT);
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < NREG; r++) pending[r] = (cnt[r] != '0);
  end

  always_comb begin
    state_d = RUN;
    unique case (1'b1)
      mem_busy: state_d = FRZ;
      stall:    state_d = HAZ;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + PCW'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table with an
// expectation queue, plus a stall-counter saturation and reset sequence.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [2:0] id_rs = '0;
  logic [2:0] id_rt = '0;
  logic [2:0] id_rd = '0;
  logic       id_check_rs = 1'b0;
  logic       id_check_rt = 1'b0;
  logic       id_writes = 1'b0;
  logic       mem_busy = 1'b0;
  logic       ex_flush = 1'b0;
  logic       stall;
  logic       issue;
  logic [7:0] pending;
  logic [1:0] state;
  logic [15:0] stall_cycles;

  int nchk = 0;
  int nerr = 0;

  hazard_scoreboard #(
    .NREG(8), .AW(3), .WB_LAT(3), .PCW(16)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_check_rs(id_check_rs),
    .id_check_rt(id_check_rt),
    .id_writes(id_writes),
    .mem_busy(mem_busy), .ex_flush(ex_flush),
    .stall(stall), .issue(issue),
    .pending(pending), .state(state),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, v;
    logic [2:0] rs, rt, rd;
    logic       crs, crt, wr, b, f;
    logic       st, is;
    logic [7:0] pd;
    logic [1:0] s;
  } vec_t;

  typedef struct {
    logic       st, is;
    logic [7:0] pd;
    logic [1:0] s;
    int         sc;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  function automatic vec_t mk(
    logic r, logic v,
    logic [2:0] rs, logic [2:0] rt, logic [2:0] rd,
    logic crs, logic crt, logic wr,
    logic b, logic f,
    logic st, logic is,
    logic [7:0] pd, logic [1:0] s);
    vec_t x;
    x.r = r; x.v = v;
    x.rs = rs; x.rt = rt; x.rd = rd;
    x.crs = crs; x.crt = crt; x.wr = wr;
    x.b = b; x.f = f;
    x.st = st; x.is = is;
    x.pd = pd; x.s = s;
    return x;
  endfunction

  function automatic vec_t idle(logic [7:0] pd, logic [1:0] s);
    return mk(0,0,0,0,0,0,0,0,0,0,0,0,pd,s);
  endfunction

  task automatic chk(string n, longint a, longint e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic drive(vec_t x);
    rst = x.r; id_valid = x.v;
    id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    id_check_rs = x.crs; id_check_rt = x.crt;
    id_writes = x.wr;
    mem_busy = x.b; ex_flush = x.f;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_sc;
    int p, nst, bad_st, bad_sc, esc;
    exp_t e;

    // reset / producer-consumer on R1
    tbl.push_back(idle(8'h00, 0));
    tbl.push_back(mk(0,1,2,3,1,1,1,1,0,0, 0,1,8'h00,0));
    tbl.push_back(mk(0,1,1,2,4,1,1,1,0,0, 1,0,8'h02,0));
    tbl.push_back(mk(0,1,1,2,4,1,1,1,0,0, 1,0,8'h02,1));
    tbl.push_back(mk(0,1,1,2,4,1,1,1,0,0, 1,0,8'h02,1));
    tbl.push_back(mk(0,1,1,2,4,1,1,1,0,0, 0,1,8'h00,1));
    tbl.push_back(idle(8'h10, 0));
    tbl.push_back(idle(8'h10, 0));
    tbl.push_back(idle(8'h10, 0));
    // independent reader after R2 producer
    tbl.push_back(mk(0,1,0,0,2,0,0,1,0,0, 0,1,8'h00,0));
    tbl.push_back(mk(0,1,3,4,5,1,1,0,0,0, 0,1,8'h04,0));
    tbl.push_back(idle(8'h04, 0));
    tbl.push_back(idle(8'h04, 0));
    tbl.push_back(idle(8'h00, 0));
    // freeze while R5 at 2
    tbl.push_back(mk(0,1,0,0,5,0,0,1,0,0, 0,1,8'h00,0));
    tbl.push_back(idle(8'h20, 0));
    tbl.push_back(mk(0,1,5,0,6,1,0,0,1,0, 0,0,8'h20,0));
    tbl.push_back(mk(0,1,5,0,6,1,0,0,1,0, 0,0,8'h20,2));
    tbl.push_back(mk(0,1,5,0,6,1,0,0,1,0, 0,0,8'h20,2));
    tbl.push_back(mk(0,1,5,0,6,1,0,0,1,0, 0,0,8'h20,2));
    tbl.push_back(mk(0,1,5,0,6,1,0,0,0,0, 1,0,8'h20,2));
    tbl.push_back(mk(0,1,5,0,6,1,0,0,0,0, 1,0,8'h20,1));
    tbl.push_back(mk(0,1,5,0,6,1,0,0,0,0, 0,1,8'h00,1));
    // flush, then flush under freeze
    tbl.push_back(mk(0,1,0,0,6,0,0,1,0,0, 0,1,8'h00,0));
    tbl.push_back(mk(0,1,6,0,7,1,0,0,0,1, 0,0,8'h40,0));
    tbl.push_back(mk(0,1,6,0,7,1,0,0,1,1, 0,0,8'h40,0));
    tbl.push_back(mk(0,1,6,0,7,1,0,0,0,0, 1,0,8'h40,2));
    tbl.push_back(mk(0,1,6,0,7,1,0,0,0,0, 1,0,8'h40,1));
    tbl.push_back(mk(0,1,6,0,7,1,0,0,0,0, 0,1,8'h00,1));
    // self-dependency and rt-only handling
    tbl.push_back(mk(0,1,1,2,1,1,1,1,0,0, 0,1,8'h00,0));
    tbl.push_back(idle(8'h02, 0));
    tbl.push_back(mk(0,1,0,1,0,0,1,0,0,0, 0,1,8'h02,0));
    tbl.push_back(mk(0,1,0,1,0,1,1,0,0,0, 1,0,8'h02,0));
    tbl.push_back(mk(0,1,0,1,0,1,1,0,0,0, 0,1,8'h00,1));
    // back-to-back writers of R3 reload the count
    tbl.push_back(mk(0,1,0,0,3,0,0,1,0,0, 0,1,8'h00,0));
    tbl.push_back(mk(0,1,0,0,3,0,0,1,0,0, 0,1,8'h08,0));
    tbl.push_back(idle(8'h08, 0));
    tbl.push_back(idle(8'h08, 0));
    tbl.push_back(idle(8'h08, 0));
    tbl.push_back(idle(8'h00, 0));
    // reset with R0 busy
    tbl.push_back(mk(0,1,0,0,0,0,0,1,0,0, 0,1,8'h00,0));
    tbl.push_back(mk(1,1,0,0,2,1,0,0,0,0, 1,0,8'h01,0));
    tbl.push_back(mk(0,1,0,0,2,1,0,0,0,0, 0,1,8'h00,0));

    repeat (2) @(posedge clk);
    #1;
    exp_sc = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      e.st = tbl[i].st; e.is = tbl[i].is;
      e.pd = tbl[i].pd; e.s = tbl[i].s;
      e.sc = exp_sc;
      sbq.push_back(e);
      if (tbl[i].r) exp_sc = 0;
      else if (tbl[i].st) exp_sc++;
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("row%0d stall", i), stall, e.st);
      chk($sformatf("row%0d issue", i), issue, e.is);
      chk($sformatf("row%0d pending", i), pending, e.pd);
      chk($sformatf("row%0d state", i), state, e.s);
      chk($sformatf("row%0d stall_cycles", i), stall_cycles, e.sc);
      @(posedge clk);
      #1;
    end

    // R7 <- f(R7) repeatedly: issue, 3 stalls, issue ...
    drive(mk(0,1,7,0,7,1,0,1,0,0, 0,0,8'h00,0));
    p = 0; nst = 0; bad_st = 0; bad_sc = 0;
    while (nst < 65541) begin
      @(negedge clk);
      if (stall !== (p != 0)) bad_st++;
      esc = (nst > 65535) ? 65535 : nst;
      if (int'(stall_cycles) != esc) bad_sc++;
      if (p != 0) nst++;
      p = (p + 1) % 4;
      @(posedge clk);
      #1;
    end
    chk("sat stall pattern errors", bad_st, 0);
    chk("sat counter track errors", bad_sc, 0);
    @(negedge clk);
    chk("sat value", stall_cycles, 16'hFFFF);
    chk("sat issue", issue, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midstall stall", stall, 1);
    @(posedge clk);
    #1;
    drive(mk(0,1,7,0,1,1,0,0,0,0, 0,0,8'h00,0));
    @(negedge clk);
    chk("post-rst pending", pending, 0);
    chk("post-rst state", state, 0);
    chk("post-rst stall_cycles", stall_cycles, 0);
    chk("post-rst issue", issue, 1);
    chk("post-rst stall", stall, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
